dmem_portb_streamer: RTL and testbench

//  Read-side counterpart to the pipeline's data-memory writes: sole owner of data-memory port B
//  (address_b / read_data_b), which the core leaves idle (address_b tied to 0).
//  On a start command it reads a contiguous word region through port B and serialises each

---
 rtl/dmem_portb_streamer.sv | 92 +++++++++
 tb/tb_dmem_portb_streamer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_portb_streamer.sv
// dmem_portb_streamer: reads a word region through memory port B and streams it MSB byte first
module dmem_portb_streamer #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] read_data_b,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = $clog2(RD_LAT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, FIN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cur_addr, remaining;
  logic [LW-1:0]     lat;
  logic [BW-1:0]     bcnt;
  logic [DATA_W-1:0] shift;
  assign out_data = shift[DATA_W-1 -: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      lat       <= '0;
      bcnt      <= '0;
      shift     <= '0;
      address_b <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else
        case (state)
          IDLE: if (start) begin
            busy      <= 1'b1;
            cur_addr  <= base_addr;
            remaining <= length;
            state     <= (length == '0) ? FIN : ISSUE;
            done      <= (length == '0);
            if (length != '0) address_b <= base_addr;
          end
          ISSUE: begin
            lat   <= LW'(RD_LAT);
            state <= WAIT;
          end
          WAIT: if (lat == LW'(1)) begin
            shift     <= read_data_b;
            bcnt      <= BW'(NB - 1);
            out_valid <= 1'b1;
            state     <= SEND;
          end else lat <= lat - 1'b1;
          SEND: if (out_ready) begin
            shift <= shift << 8;
            if (bcnt == '0) begin
              out_valid <= 1'b0;
              cur_addr  <= cur_addr + 1'b1;
              remaining <= remaining - 1'b1;
              // the next word's address is registered on entry to ISSUE
              if (remaining == ADDR_W'(1)) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                state     <= ISSUE;
                address_b <= cur_addr + 1'b1;
              end
            end else bcnt <= bcnt - 1'b1;
          end
          FIN: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_portb_streamer.sv
// tb_dmem_portb_streamer: scoreboard bench for the port-B dump streamer
module tb_dmem_portb_streamer;
  localparam int AW = 18;
  localparam int DW = 24;
  logic clk = 0, rst = 1, start = 0, abort = 0, out_ready = 0;
  logic [AW-1:0] base_addr = 0, length = 0, address_b;
  logic [DW-1:0] rd1;
  logic [7:0] out_data;
  logic out_valid, busy, done;
  logic rst3 = 1, start3 = 0, abort3 = 0, ready3 = 1;
  logic [AW-1:0] base3 = 0, len3 = 0, a3;
  logic [DW-1:0] p0, p1, rd3;
  logic [7:0] d3;
  logic v3, busy3, done3;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int total = 0, bad = 0, dcount = 0;
  logic [7:0] q1[$], q3[$];
  logic hold = 0, hold_ab = 0;
  logic [7:0] hold_d = 0;

  dmem_portb_streamer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .length(length), .address_b(address_b), .read_data_b(rd1), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done));

  dmem_portb_streamer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .abort(abort3), .base_addr(base3),
    .length(len3), .address_b(a3), .read_data_b(rd3), .out_data(d3),
    .out_valid(v3), .out_ready(ready3), .busy(busy3), .done(done3));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    rd1 <= mem[address_b];
    p0  <= mem[a3];
    p1  <= p0;
    rd3 <= p1;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) dcount++;
      if (hold && !hold_ab) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
      end
      if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte got=%0h want=none", out_data);
        end else chk("byte", out_data, q1.pop_front());
      end
      hold    = out_valid && !out_ready;
      hold_ab = abort;
      hold_d  = out_data;
    end else hold = 0;
  end

  always @(negedge clk)
    if (!rst3 && v3 && ready3) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte3 got=%0h want=none", d3);
      end else chk("byte3", d3, q3.pop_front());
    end

  initial begin
    logic [AW-1:0] a0;
    int d0, n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    tick(); tick();
    rst = 0;
    rst3 = 0;
    chk("rst_addr", address_b, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    tick();
    // single word, timing pinned cycle by cycle
    mem[18'h10] = 24'hABCDEF;
    q1.push_back(8'hAB); q1.push_back(8'hCD); q1.push_back(8'hEF);
    start = 1; base_addr = 18'h10; length = 1; out_ready = 1;
    tick();
    start = 0;
    chk("t1_busy", busy, 1);
    chk("t1_addr", address_b, 18'h10);
    tick();
    chk("t1_novalid", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_b0", out_data, 8'hAB);
    tick();
    chk("t1_b1", out_data, 8'hCD);
    tick();
    chk("t1_b2", out_data, 8'hEF);
    tick();
    chk("t1_done", done, 1);
    chk("t1_v_off", out_valid, 0);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_q", q1.size(), 0);
    // three words with a toggling sink
    mem[18'h20] = 24'h010203; mem[18'h21] = 24'h040506; mem[18'h22] = 24'h070809;
    for (int i = 1; i <= 9; i++) q1.push_back(8'(i));
    start = 1; base_addr = 18'h20; length = 3;
    tick();
    start = 0;
    n = 0;
    while (!done && n < 300) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    chk("t2_done", done, 1);
    chk("t2_q", q1.size(), 0);
    out_ready = 1;
    tick();
    // zero length
    a0 = address_b;
    d0 = dcount;
    start = 1; base_addr = 18'h100; length = 0;
    tick();
    start = 0;
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 1);
    chk("t3_addr", address_b, a0);
    chk("t3_valid", out_valid, 0);
    tick();
    chk("t3_done_off", done, 0);
    chk("t3_idle", busy, 0);
    chk("t3_valid2", out_valid, 0);
    chk("t3_dcount", dcount, d0 + 1);
    // address wrap
    mem[18'h3FFFF] = 24'h112233; mem[0] = 24'h445566;
    q1.push_back(8'h11); q1.push_back(8'h22); q1.push_back(8'h33);
    q1.push_back(8'h44); q1.push_back(8'h55); q1.push_back(8'h66);
    start = 1; base_addr = 18'h3FFFF; length = 2;
    tick();
    start = 0;
    chk("t4_addr0", address_b, 18'h3FFFF);
    wait_done(100);
    chk("t4_addr1", address_b, 0);
    chk("t4_q", q1.size(), 0);
    tick();
    // abort with a byte pending
    mem[18'h40] = 24'hA1A2A3; mem[18'h41] = 24'hB1B2B3; mem[18'h50] = 24'hC0FFEE;
    q1.push_back(8'hA1); q1.push_back(8'hA2);
    start = 1; base_addr = 18'h40; length = 2;
    tick();
    start = 0;
    tick(); tick(); tick(); tick();
    out_ready = 0;
    abort = 1;
    chk("t5_pending_v", out_valid, 1);
    chk("t5_pending_d", out_data, 8'hA3);
    d0 = dcount;
    tick();
    abort = 0;
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    tick(); tick(); tick();
    chk("t5_nodone", dcount, d0);
    chk("t5_q", q1.size(), 0);
    out_ready = 1;
    q1.push_back(8'hC0); q1.push_back(8'hFF); q1.push_back(8'hEE);
    start = 1; base_addr = 18'h50; length = 1;
    tick();
    start = 0;
    chk("t5_addr", address_b, 18'h50);
    wait_done(50);
    chk("t5_q2", q1.size(), 0);
    tick();
    // reset mid-WAIT on the RD_LAT=3 instance
    mem[18'h60] = 24'h123456; mem[18'h61] = 24'h789ABC;
    start3 = 1; base3 = 18'h60; len3 = 1;
    tick();
    start3 = 0;
    tick(); tick();
    chk("t6_busy", busy3, 1);
    chk("t6_addr", a3, 18'h60);
    rst3 = 1;
    #1;
    chk("t6_rbusy", busy3, 0);
    chk("t6_raddr", a3, 0);
    chk("t6_rvalid", v3, 0);
    chk("t6_rdata", d3, 0);
    chk("t6_rdone", done3, 0);
    start3 = 1;
    tick(); tick();
    chk("t6_rstart", busy3, 0);
    start3 = 0;
    rst3 = 0;
    tick();
    q3.push_back(8'h78); q3.push_back(8'h9A); q3.push_back(8'hBC);
    start3 = 1; base3 = 18'h61;
    tick();
    start3 = 0;
    chk("t6_addr2", a3, 18'h61);
    tick(); tick(); tick();
    chk("t6_novalid", v3, 0);
    tick();
    chk("t6_valid", v3, 1);
    chk("t6_b0", d3, 8'h78);
    n = 0;
    while (!done3 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_done", done3, 1);
    chk("t6_q", q3.size(), 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
